// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory-system port (one mem_sys_axil_wrapper) between the
// instruction fetch unit (IFU) and the load/store unit (LSU). One transaction is
// granted at a time. The winner's command is latched and driven to the wrapper,
// and the wrapper's completion pulse is routed back to the winner. A pipeline
// flush kills an in-flight fetch: the wrapper transaction still runs to
// completion, but its ifu_done is suppressed.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_GUARD_EN):
//   Starvation guard. After STARVE_MAX consecutive LSU grants made while the
//   IFU was waiting, the next grant goes to the IFU. Without the macro the LSU
//   always has strict priority.
//
// Parameters
//   XLEN        address/data width
//   STARVE_MAX  LSU grants tolerated while the IFU waits (guard only)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   pipeline flush, kills an in-flight fetch
//   ifu_req/ifu_addr        fetch request (held until ifu_done or flush)
//   ifu_rdata/ifu_done      fetch data and one-cycle completion
//   lsu_req/lsu_wr/lsu_addr/lsu_wdata/lsu_be
//                           load/store request (held until lsu_done)
//   lsu_rdata/lsu_done      load data and one-cycle completion
//   mem_addr/mem_wdata/mem_be/mem_rd/mem_wr/mem_valid
//                           latched command and strobes to the wrapper
//   mem_rdata/mem_done      wrapper read data and one-cycle completion
//   busy                    high in any grant state
//   state_dbg               FSM state: 0=IDLE 1=GNT_IFU 2=GNT_LSU 3=GNT_KILL
//
// Handshake: a requester raises *_req with its fields stable and keeps them so
// until its *_done pulse (or, for the IFU, until a flush). The arbiter grants
// one cycle after seeing the request in IDLE; mem_valid then stays high with the
// command constant until mem_done, and the following cycle is always IDLE so a
// stale request is never granted twice.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ifu_req,
  input  logic [XLEN-1:0] ifu_addr,
  output logic [XLEN-1:0] ifu_rdata,
  output logic            ifu_done,
  input  logic            lsu_req,
  input  logic            lsu_wr,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [3:0]      lsu_be,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_done,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            mem_valid,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_done,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GNT_IFU  = 2'd1;
  localparam logic [1:0] ST_GNT_LSU  = 2'd2;
  localparam logic [1:0] ST_GNT_KILL = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       cmd_rd;
  logic       cmd_wr;
  logic       grant_ifu;
  logic       grant_lsu;
  logic       starve_hit;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CW'(STARVE_MAX)) && ifu_req && !flush;

  // Counts LSU grants that overtook a waiting fetch. Saturates at STARVE_MAX so
  // an LSU grant that happens while a flush blocks the IFU cannot push the
  // count past the compare value and silently disable the guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_ifu || !ifu_req) begin
        starve_cnt <= '0;
      end else if (grant_lsu && (starve_cnt != CW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end
`else
  // Strict LSU priority; STARVE_MAX is only meaningful with the guard, and a
  // legal STARVE_MAX is never negative, so this is constant zero.
  assign starve_hit = (STARVE_MAX < 0);
`endif

  // ---------------------------------------------------------------------------
  // Grant decision (only acted on in IDLE)
  // ---------------------------------------------------------------------------
  assign grant_ifu = (state == ST_IDLE) && ifu_req && !flush && (starve_hit || !lsu_req);
  assign grant_lsu = (state == ST_IDLE) && lsu_req && !grant_ifu;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_nxt = ST_GNT_LSU;
        end else if (grant_ifu) begin
          state_nxt = ST_GNT_IFU;
        end
      end
      ST_GNT_IFU: begin
        // A flush in the completion cycle needs no kill state: the done is
        // simply suppressed below.
        if (mem_done) begin
          state_nxt = ST_IDLE;
        end else if (flush) begin
          state_nxt = ST_GNT_KILL;
        end
      end
      ST_GNT_LSU: begin
        if (mem_done) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT_KILL: begin
        if (mem_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Command latch: captured on the grant edge, held for the whole grant
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
    end else if (grant_lsu) begin
      mem_addr  <= lsu_addr;
      mem_wdata <= lsu_wdata;
      mem_be    <= lsu_be;
      cmd_rd    <= !lsu_wr;
      cmd_wr    <= lsu_wr;
    end else if (grant_ifu) begin
      mem_addr  <= ifu_addr;
      mem_wdata <= '0;
      mem_be    <= 4'hF;
      cmd_rd    <= 1'b1;
      cmd_wr    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (state != ST_IDLE);
  assign mem_valid = busy;
  // The latched rd/wr bits linger after a grant; masking with busy keeps the
  // strobes low in IDLE without another clear path on the latch.
  assign mem_rd    = cmd_rd && busy;
  assign mem_wr    = cmd_wr && busy;

  assign ifu_done  = (state == ST_GNT_IFU) && mem_done && !flush;
  assign lsu_done  = (state == ST_GNT_LSU) && mem_done;

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;
  // Scoreboard entry: {who(1=lsu), addr, wdata, be, rd, wr}
  localparam int E_W        = 2 * XLEN + 7;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            ifu_req;
  logic [XLEN-1:0] ifu_addr;
  logic [XLEN-1:0] ifu_rdata;
  logic            ifu_done;
  logic            lsu_req;
  logic            lsu_wr;
  logic [XLEN-1:0] lsu_addr;
  logic [XLEN-1:0] lsu_wdata;
  logic [3:0]      lsu_be;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_done;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rd;
  logic            mem_wr;
  logic            mem_valid;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_done;
  logic            busy;
  logic [1:0]      state_dbg;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata), .ifu_done(ifu_done),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_be(lsu_be), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_valid(mem_valid), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: timed out", name, $time);
  endtask

  // Memory contents as seen by the wrapper model.
  function automatic logic [XLEN-1:0] rdata_of(input logic [XLEN-1:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // ---------------------------------------------------------------------------
  // Wrapper model: completes each grant lat cycles after it starts
  // ---------------------------------------------------------------------------
  int lat_fix = 0;  // 0 selects a random latency 1..4
  int w_cnt   = 0;
  bit w_out   = 0;

  initial begin
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || mem_done) begin
        mem_done = 1'b0;
        w_out    = 1'b0;
      end else if (w_out) begin
        w_cnt--;
        if (w_cnt == 0) begin
          mem_done  = 1'b1;
          mem_rdata = rdata_of(mem_addr);
        end
      end else if (mem_valid) begin
        w_out = 1'b1;
        w_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model + scoreboard monitor (samples on negedge)
  // ---------------------------------------------------------------------------
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] m_ent;
  bit             m_busy   = 0;
  bit             m_pend   = 0;
  bit             m_killed = 0;
  int             starve   = 0;
  int             lsu_done_cnt = 0;

  initial begin
    bit exp_ifu;
    bit exp_lsu;
    bit force_ifu;
    m_ent = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_pend = 0; m_killed = 0; starve = 0;
        exp_q.delete();
      end else begin
        if (m_pend) begin
          m_pend   = 0;
          m_busy   = 1;
          m_killed = 0;
          m_ent    = exp_q.pop_front();
        end
        check("busy", busy, m_busy);
        check("mem_valid", mem_valid, m_busy);
        if (m_busy) begin
          check("mem_addr",  mem_addr,  m_ent[2*XLEN+5:XLEN+6]);
          check("mem_wdata", mem_wdata, m_ent[XLEN+5:6]);
          check("mem_be",    mem_be,    m_ent[5:2]);
          check("mem_rd",    mem_rd,    m_ent[1]);
          check("mem_wr",    mem_wr,    m_ent[0]);
        end else begin
          check("mem_rd_idle", mem_rd, 0);
          check("mem_wr_idle", mem_wr, 0);
        end
        exp_ifu = m_busy && mem_done && !m_ent[E_W-1] && !m_killed && !flush;
        exp_lsu = m_busy && mem_done && m_ent[E_W-1];
        check("ifu_done", ifu_done, exp_ifu);
        check("lsu_done", lsu_done, exp_lsu);
        if (exp_ifu) check("ifu_rdata", ifu_rdata, rdata_of(m_ent[2*XLEN+5:XLEN+6]));
        if (exp_lsu) check("lsu_rdata", lsu_rdata, rdata_of(m_ent[2*XLEN+5:XLEN+6]));
        if (lsu_done) lsu_done_cnt++;

        if (m_busy) begin
          if (mem_done) m_busy = 0;
          else if (!m_ent[E_W-1] && flush) m_killed = 1;
        end else begin
          // Arbitration rules: LSU first, IFU only without flush, and with the
          // guard the IFU wins once STARVE_MAX LSU grants overtook it.
          if (!ifu_req) starve = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
          force_ifu = (starve == STARVE_MAX) && ifu_req && !flush;
`else
          force_ifu = 0;
`endif
          if (ifu_req && !flush && (force_ifu || !lsu_req)) begin
            exp_q.push_back({1'b0, ifu_addr, {XLEN{1'b0}}, 4'hF, 1'b1, 1'b0});
            m_pend = 1;
            starve = 0;
          end else if (lsu_req) begin
            exp_q.push_back({1'b1, lsu_addr, lsu_wdata, lsu_be, !lsu_wr, lsu_wr});
            m_pend = 1;
            if (ifu_req && starve < STARVE_MAX) starve++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // flush_at >= 0: flush during that grant cycle (0 = first), only used alone.
  task automatic do_ifu(input logic [XLEN-1:0] a, input int flush_at, input bit rnd_flush);
    int cyc  = 0;
    int gcyc = -1;
    bit fin  = 0;
    @(posedge clk); #1;
    ifu_req  = 1'b1;
    ifu_addr = a;
    while (!fin) begin
      @(negedge clk);
      if (ifu_done || !rst_n) begin
        fin = 1;
      end else if (cyc >= 300) begin
        timeout_fail("ifu_wait");
        fin = 1;
      end else begin
        cyc++;
        if (gcyc >= 0) gcyc++;
        else if (mem_valid) gcyc = 0;
        if ((flush_at >= 0 && gcyc == flush_at - 1) ||
            (rnd_flush && $urandom_range(0, 15) == 0)) begin
          @(posedge clk); #1;
          flush   = 1'b1;
          ifu_req = 1'b0;
          @(posedge clk); #1;
          flush   = 1'b0;
          fin     = 1;
        end
      end
    end
    @(posedge clk); #1;
    ifu_req = 1'b0;
  endtask

  task automatic do_lsu(input bit wr, input logic [XLEN-1:0] a, input logic [XLEN-1:0] wd,
                        input logic [3:0] be, input bit drop);
    int cyc = 0;
    bit fin = 0;
    bit aborted = 0;
    @(posedge clk); #1;
    lsu_req   = 1'b1;
    lsu_wr    = wr;
    lsu_addr  = a;
    lsu_wdata = wd;
    lsu_be    = be;
    while (!fin) begin
      @(negedge clk);
      if (lsu_done) begin
        fin = 1;
      end else if (!rst_n) begin
        fin = 1;
        aborted = 1;
      end else if (cyc >= 300) begin
        timeout_fail("lsu_wait");
        fin = 1;
      end else begin
        cyc++;
      end
    end
    if (drop || aborted) begin
      @(posedge clk); #1;
      lsu_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 100);
    if (busy) timeout_fail("wait_idle");
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int ifu_after;
  int base;
  int exp_before;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_wr = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be",    mem_be,    0);
    check("rst_mem_rd",    mem_rd,    0);
    check("rst_mem_wr",    mem_wr,    0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_ifu_done",  ifu_done,  0);
    check("rst_lsu_done",  lsu_done,  0);
    check("rst_state",     state_dbg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Lone fetch, 3-cycle wrapper
    lat_fix = 3;
    do_ifu(32'h100, -1, 0);
    wait_idle();

    // Store with partial byte enables
    do_lsu(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    wait_idle();

    // Contention: LSU first, IFU after the bubble
    lat_fix = 2;
    fork
      do_ifu(32'h400, -1, 0);
      do_lsu(1'b0, 32'h800, 32'h0, 4'hF, 1'b1);
    join
    wait_idle();

    // Flush in grant cycle 1 of a fetch: killed, wrapper still completes
    lat_fix = 4;
    do_ifu(32'h500, 1, 0);
    @(negedge clk);
    check("kill_state", state_dbg, 3);
    check("kill_valid", mem_valid, 1);
    check("kill_ifu_done", ifu_done, 0);
    wait_idle();

    // Flush coinciding with mem_done
    lat_fix = 3;
    do_ifu(32'h600, 3, 0);
    wait_idle();

    // Flush while idle blocks a fetch grant
    lat_fix = 2;
    @(posedge clk); #1;
    flush = 1'b1; ifu_req = 1'b1; ifu_addr = 32'h300;
    repeat (2) begin
      @(negedge clk);
      check("flush_idle_no_grant", busy, 0);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!ifu_done && k < 50);
      if (!ifu_done) timeout_fail("flush_idle_fetch");
    end
    @(posedge clk); #1;
    ifu_req = 1'b0;
    wait_idle();

    // Starvation: both requests held, five LSU transactions queued
    lat_fix = 1;
    base = lsu_done_cnt;
    fork
      begin
        do_ifu(32'h700, -1, 0);
        ifu_after = lsu_done_cnt - base;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          do_lsu(1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF, i == 4);
        end
      end
    join
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_before = STARVE_MAX;
`else
    exp_before = 5;
`endif
    check("starve_lsu_before_ifu", ifu_after, exp_before);
    wait_idle();

    // Randomized traffic with random fetch flushes
    lat_fix = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_ifu($urandom & 32'hFFFF_FFFC, -1, 1);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_lsu(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 4'($urandom_range(1, 15)), 1'b1);
        end
      end
    join
    wait_idle();

    // Reset in the middle of an LSU grant
    lat_fix = 8;
    fork
      do_lsu(1'b0, 32'hA0, 32'h0, 4'hF, 1'b1);
      begin
        int k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!mem_valid && k < 50);
        if (!mem_valid) timeout_fail("rst_test_grant");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_valid", mem_valid, 0);
        check("midrst_busy",      busy,      0);
        check("midrst_mem_rd",    mem_rd,    0);
        check("midrst_mem_wr",    mem_wr,    0);
        check("midrst_mem_addr",  mem_addr,  0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_mem_be",    mem_be,    0);
        check("midrst_lsu_done",  lsu_done,  0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    join

    // Fresh load after reset release
    lat_fix = 2;
    base = lsu_done_cnt;
    do_lsu(1'b0, 32'hB4, 32'h0, 4'hF, 1'b1);
    wait_idle();
    check("post_rst_lsu_done_count", lsu_done_cnt - base, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single memory-system port (the AXI-Lite memory wrapper) between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the fetch and memory stages and one `mem_sys_axil_wrapper` instance. It grants one transaction at a time, latches that requester's command, drives the wrapper, and routes the completion pulse back. Fetch completions are suppressed after a pipeline flush.

## Interface
- `XLEN`, default 32: address/data width.
- `STARVE_MAX`, default 4: consecutive LSU grants allowed while IFU waits; used only with the starvation guard.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `flush`  in  1  pipeline flush; kills any in-flight IFU transaction.
- `ifu_req`  in  1  fetch request; held with `ifu_addr` stable until `ifu_done` or flush.
- `ifu_addr`  in  XLEN  fetch address.
- `ifu_rdata`  out  XLEN  fetch data; valid when `ifu_done`=1.
- `ifu_done`  out  1  one-cycle fetch completion.
- `lsu_req`  in  1  load/store request; held with fields stable until `lsu_done`.
- `lsu_wr`  in  1  1=store, 0=load.
- `lsu_addr`  in  XLEN  data address.
- `lsu_wdata`  in  XLEN  store data.
- `lsu_be`  in  4  byte enables.
- `lsu_rdata`  out  XLEN  load data; valid when `lsu_done`=1.
- `lsu_done`  out  1  one-cycle load/store completion.
- `mem_addr`, `mem_wdata`  out  XLEN  latched command to wrapper.
- `mem_rd`, `mem_wr`, `mem_valid`  out  1  wrapper strobes.
- `mem_be`  out  4  latched byte enables.
- `mem_rdata`  in  XLEN  wrapper read data.
- `mem_done`  in  1  wrapper one-cycle completion.
- `busy`  out  1  high in any grant state.

## Operation
- States: IDLE, GNT_IFU, GNT_LSU, GNT_KILL.
- IDLE:
  - If `lsu_req` is high, latch the LSU command and go to GNT_LSU.
  - Else if `ifu_req` is high and `flush` is low, latch the IFU command (rd=1, wr=0, be=4'hF, wdata=0) and go to GNT_IFU.
  - Else stay in IDLE.
- Priority is fixed LSU over IFU, unless the starvation guard forces an IFU grant.
- GNT_IFU:
  - On `mem_done`, assert `ifu_done` and go to IDLE.
  - On `flush` without `mem_done`, go to GNT_KILL.
  - On `flush` together with `mem_done`, suppress `ifu_done` and go to IDLE.
- GNT_KILL: wait for `mem_done`. `ifu_done` is never asserted in this state. Go to IDLE. The downstream transaction always runs to completion and is never abandoned.
- GNT_LSU: on `mem_done`, assert `lsu_done` and go to IDLE. `flush` is ignored in this state.
- `mem_valid` = `busy`. `mem_rd`/`mem_wr` come from the latched command and are zero in IDLE.
- `ifu_rdata` and `lsu_rdata` are both a passthrough of `mem_rdata`. Only the `*_done` signals are gated.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_addr`, `mem_wdata`, `mem_be` = 0.
  - `mem_rd`, `mem_wr`, `mem_valid`, `busy` = 0.
  - `ifu_done`, `lsu_done` = 0.
  - Starvation counter = 0.
- Request high in IDLE at cycle t gives grant state and `mem_valid`=1 at t+1.
- `*_done` is combinational from `mem_done` in the same cycle.
- The state is IDLE in the cycle after `mem_done`. This is a mandatory one-cycle bubble between transactions, so a requester's stale `req` is never re-granted.
- Minimum turnaround is therefore wrapper latency + 2 cycles per transaction.
- Latched `mem_*` fields hold constant for the whole grant.
- Simultaneous `ifu_req` and `lsu_req` in IDLE: LSU wins, subject to the starvation guard.
- Reset asserted mid-grant returns to IDLE asynchronously with all strobes low. The wrapper shares `rst_n`.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter of width $clog2(STARVE_MAX+1) increments on each LSU grant made while `ifu_req` is high.
  - The counter clears on any IFU grant, and whenever `ifu_req` is low in IDLE.
  - When the counter equals `STARVE_MAX` and `ifu_req` is high with `flush` low, IDLE grants the IFU even if `lsu_req` is high.
- Not defined: strict LSU priority. No counter logic is present.

## Test plan
- Lone fetch: `ifu_addr`=0x100, wrapper returns 0x00000013 after 3 cycles -> `mem_rd`=1, `mem_addr`=0x100, `mem_be`=4'hF, `ifu_done` one cycle with `ifu_rdata`=0x13, `lsu_done` never asserted.
- Store: `lsu_wr`=1, `lsu_addr`=0x2000, `lsu_wdata`=0xDEADBEEF, `lsu_be`=4'b0011 -> `mem_wr`=1 with those values latched, `lsu_done` pulses once, and a bubble cycle with `busy`=0 follows.
- Contention: both requests high in the same cycle -> LSU served first, then IFU granted after the bubble.
- Flush mid-fetch: flush at cycle 1 of a 4-cycle fetch -> state GNT_KILL, `mem_valid` stays high until `mem_done`, `ifu_done` stays 0; flush together with `mem_done` -> `ifu_done` stays 0.
- Starvation (macro on, `STARVE_MAX`=4): `ifu_req` and `lsu_req` held continuously -> 4 LSU grants, then 1 IFU grant, then the counter is back at 0. With the macro off -> the IFU is never granted.
- Reset mid-LSU grant -> all outputs 0 immediately; a fresh request after reset release completes normally.
